tinyqv_fetch_buffer: RTL and testbench

Instruction prefetch buffer sitting directly upstream of the instruction decoder. Accepts a stream of 16-bit halfwords from the memory/QSPI controller, holds them in a small circular queue, and presents an aligned 32-bit instruction word (or a 16-bit compressed instruction) to the decoder with a valid flag. Consumes 1 or 2 halfwords per retired instruction as told by the decoder's length output, and restarts the fetch stream on a control-flow flush.

---
 rtl/tinyqv_fetch_buffer.sv | 94 +++++++++
 tb/tb_tinyqv_fetch_buffer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyqv_fetch_buffer.sv
// Instruction prefetch buffer: circular queue of 16-bit halfwords from memory,
// presenting a 32-bit (or compressed 16-bit) instruction to the decoder.
module tinyqv_fetch_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_data,
  input  logic        mem_data_valid,
  output logic        mem_data_ready,
  output logic [22:0] mem_addr,
  output logic        mem_restart,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        instr_compressed,
  output logic [22:0] instr_pc,
  input  logic        advance,
  input  logic [1:0]  advance_len,
  input  logic        flush,
  input  logic [22:0] flush_addr
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = 23;

  logic [15:0]   buf_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          has_one;
  logic          has_two;
  logic          push;
  logic          pop;
  logic [15:0]   head_hw;
  logic [15:0]   next_hw;
  logic [CW-1:0] pop_cnt;

  // Head view, gated by occupancy so stale storage never leaks out
  always_comb begin
    has_one          = (count != '0);
    has_two          = (count >= CW'(2));
    head_hw          = has_one ? buf_q[rd_ptr] : 16'h0000;
    next_hw          = has_two ? buf_q[rd_ptr + PW'(1)] : 16'h0000;
    instr            = {next_hw, head_hw};
    instr_compressed = has_one && (head_hw[1:0] != 2'b11);
    instr_valid      = instr_compressed || has_two;
  end

  // Handshakes; a full buffer refuses even when a pop frees a slot this cycle
  always_comb begin
    mem_data_ready = (count < CW'(DEPTH)) && !flush;
    push           = mem_data_valid && mem_data_ready;
    pop            = advance && instr_valid &&
                     ((advance_len == 2'b01) || ((advance_len == 2'b10) && has_two));
    pop_cnt        = pop ? CW'(advance_len) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      mem_addr    <= '0;
      instr_pc    <= '0;
      mem_restart <= 1'b0;
    end else if (flush) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      mem_addr    <= flush_addr;
      instr_pc    <= flush_addr;
      mem_restart <= 1'b1;
    end else begin
      mem_restart <= 1'b0;
      count       <= count + CW'(push) - pop_cnt;
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        mem_addr <= mem_addr + AW'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(advance_len);
        instr_pc <= instr_pc + AW'(advance_len);
      end
    end
  end

  // Storage needs no reset: contents are only observed through count
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr] <= mem_data;
  end

endmodule

// File: tb/tb_tinyqv_fetch_buffer.sv
// Bench for tinyqv_fetch_buffer: directed vector table plus randomized stream
// checked against a queue-based reference model.
module tb_tinyqv_fetch_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_data;
  logic        mem_data_valid;
  logic        mem_data_ready;
  logic [22:0] mem_addr;
  logic        mem_restart;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_compressed;
  logic [22:0] instr_pc;
  logic        advance;
  logic [1:0]  advance_len;
  logic        flush;
  logic [22:0] flush_addr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tinyqv_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_data(mem_data), .mem_data_valid(mem_data_valid), .mem_data_ready(mem_data_ready),
    .mem_addr(mem_addr), .mem_restart(mem_restart),
    .instr(instr), .instr_valid(instr_valid), .instr_compressed(instr_compressed),
    .instr_pc(instr_pc),
    .advance(advance), .advance_len(advance_len),
    .flush(flush), .flush_addr(flush_addr)
  );

  // Observation word: {valid, compressed, ready, restart, instr, pc, mem_addr}
  function automatic logic [81:0] mk(input logic v, input logic c, input logic rdy,
                                     input logic rs, input logic [31:0] ins,
                                     input logic [22:0] pc, input logic [22:0] ma);
    return {v, c, rdy, rs, ins, pc, ma};
  endfunction

  function automatic logic [81:0] dut_obs();
    return mk(instr_valid, instr_compressed, mem_data_ready, mem_restart, instr, instr_pc, mem_addr);
  endfunction

  task automatic check(input string name, input logic [81:0] act, input logic [81:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got v=%b c=%b rdy=%b rs=%b instr=%h pc=%h ma=%h, want v=%b c=%b rdy=%b rs=%b instr=%h pc=%h ma=%h",
               name, act[81], act[80], act[79], act[78], act[77:46], act[45:23], act[22:0],
               exp[81], exp[80], exp[79], exp[78], exp[77:46], exp[45:23], exp[22:0]);
    end
  endtask

  task automatic idle_inputs();
    mem_data_valid = 1'b0;
    mem_data       = 16'h0;
    advance        = 1'b0;
    advance_len    = 2'b00;
    flush          = 1'b0;
    flush_addr     = 23'h0;
  endtask

  // Drive one cycle, then observe with inputs idle so ready is not masked by flush
  task automatic cycle(input logic mv, input logic [15:0] md, input logic adv,
                       input logic [1:0] len, input logic fl, input logic [22:0] fa);
    mem_data_valid = mv;
    mem_data       = md;
    advance        = adv;
    advance_len    = len;
    flush          = fl;
    flush_addr     = fa;
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        mv;
    logic [15:0] md;
    logic        adv;
    logic [1:0]  len;
    logic        fl;
    logic [22:0] fa;
    logic [81:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic mv, input logic [15:0] md, input logic adv,
                     input logic [1:0] len, input logic fl, input logic [22:0] fa,
                     input logic [81:0] exp);
    vec_t v;
    v.name = nm; v.mv = mv; v.md = md; v.adv = adv; v.len = len;
    v.fl = fl; v.fa = fa; v.exp = exp;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  logic [15:0] mq[$];
  logic [22:0] m_pc;
  logic [22:0] m_addr;
  logic        m_restart;

  function automatic logic [81:0] model_obs();
    logic [15:0] h0, h1;
    logic        c, v;
    h0 = 16'h0;
    h1 = 16'h0;
    if (mq.size() >= 1) h0 = mq[0];
    if (mq.size() >= 2) h1 = mq[1];
    c = (mq.size() >= 1) && (h0[1:0] != 2'b11);
    v = c || (mq.size() >= 2);
    return mk(v, c, mq.size() < DEPTH, m_restart, {h1, h0}, m_pc, m_addr);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc = '0;
    m_addr = '0;
    m_restart = 1'b0;
  endtask

  task automatic model_step(input logic mv, input logic [15:0] md, input logic adv,
                            input logic [1:0] len, input logic fl, input logic [22:0] fa);
    logic [81:0] o;
    logic        can_push, can_pop;
    o = model_obs();
    if (fl) begin
      mq.delete();
      m_pc = fa;
      m_addr = fa;
      m_restart = 1'b1;
    end else begin
      m_restart = 1'b0;
      can_push = mv && (mq.size() < DEPTH);
      can_pop  = adv && o[81] && (len == 2'd1 || (len == 2'd2 && mq.size() >= 2));
      if (can_pop) begin
        for (int k = 0; k < int'(len); k++) void'(mq.pop_front());
        m_pc = m_pc + 23'(len);
      end
      if (can_push) begin
        mq.push_back(md);
        m_addr = m_addr + 23'd1;
      end
    end
  endtask

  task automatic random_cycles(input int n);
    logic        mv, adv, fl;
    logic [15:0] md;
    logic [1:0]  len;
    logic [22:0] fa;
    int          r;
    for (int i = 0; i < n; i++) begin
      mv  = ($urandom_range(0, 3) != 0);
      md  = 16'($urandom);
      adv = ($urandom_range(0, 2) != 0);
      r   = $urandom_range(0, 9);
      len = (r == 0) ? 2'd0 : (r == 1) ? 2'd3 : (r < 6) ? 2'd1 : 2'd2;
      fl  = ($urandom_range(0, 39) == 0);
      fa  = ($urandom_range(0, 3) == 0) ? 23'h7ffffe : 23'($urandom);
      model_step(mv, md, adv, len, fl, fa);
      cycle(mv, md, adv, len, fl, fa);
      check("random", dut_obs(), model_obs());
    end
  endtask

  localparam logic [81:0] RESET_OBS = {1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 23'h0, 23'h0};

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    check("reset_held", dut_obs(), RESET_OBS);
    rst = 1'b0;
    #1;
    check("reset_release", dut_obs(), RESET_OBS);

    //       name            mv  data      adv len   fl  faddr        v  c  rdy rs instr          pc          mem_addr
    add("push_0513",       1, 16'h0513, 0, 2'd0, 0, 23'h0, mk(0, 0, 1, 0, 32'h00000513, 23'h0, 23'h1));
    add("push_0000",       1, 16'h0000, 0, 2'd0, 0, 23'h0, mk(1, 0, 1, 0, 32'h00000513, 23'h0, 23'h2));
    add("pop_addi",        0, 16'h0000, 1, 2'd2, 0, 23'h0, mk(0, 0, 1, 0, 32'h0,        23'h2, 23'h2));
    add("push_c4501",      1, 16'h4501, 0, 2'd0, 0, 23'h0, mk(1, 1, 1, 0, 32'h00004501, 23'h2, 23'h3));
    add("len2_one_hw",     0, 16'h0000, 1, 2'd2, 0, 23'h0, mk(1, 1, 1, 0, 32'h00004501, 23'h2, 23'h3));
    add("len3_ignored",    0, 16'h0000, 1, 2'd3, 0, 23'h0, mk(1, 1, 1, 0, 32'h00004501, 23'h2, 23'h3));
    add("len0_ignored",    0, 16'h0000, 1, 2'd0, 0, 23'h0, mk(1, 1, 1, 0, 32'h00004501, 23'h2, 23'h3));
    add("pop_c",           0, 16'h0000, 1, 2'd1, 0, 23'h0, mk(0, 0, 1, 0, 32'h0,        23'h3, 23'h3));
    add("fill1",           1, 16'h1111, 0, 2'd0, 0, 23'h0, mk(1, 1, 1, 0, 32'h00001111, 23'h3, 23'h4));
    add("fill2",           1, 16'h2223, 0, 2'd0, 0, 23'h0, mk(1, 1, 1, 0, 32'h22231111, 23'h3, 23'h5));
    add("fill3",           1, 16'h3333, 0, 2'd0, 0, 23'h0, mk(1, 1, 1, 0, 32'h22231111, 23'h3, 23'h6));
    add("fill4_full",      1, 16'h4447, 0, 2'd0, 0, 23'h0, mk(1, 1, 0, 0, 32'h22231111, 23'h3, 23'h7));
    add("full_refuse",     1, 16'h5555, 0, 2'd0, 0, 23'h0, mk(1, 1, 0, 0, 32'h22231111, 23'h3, 23'h7));
    add("full_pop_push",   1, 16'h6666, 1, 2'd1, 0, 23'h0, mk(1, 0, 1, 0, 32'h33332223, 23'h4, 23'h7));
    add("pop_len2",        0, 16'h0000, 1, 2'd2, 0, 23'h0, mk(0, 0, 1, 0, 32'h00004447, 23'h6, 23'h7));
    add("adv_not_valid",   1, 16'h0001, 1, 2'd1, 0, 23'h0, mk(1, 0, 1, 0, 32'h00014447, 23'h6, 23'h8));
    add("push_count3",     1, 16'h7777, 0, 2'd0, 0, 23'h0, mk(1, 0, 1, 0, 32'h00014447, 23'h6, 23'h9));
    add("flush_100",       1, 16'h9999, 1, 2'd1, 1, 23'h100, mk(0, 0, 1, 1, 32'h0,       23'h100, 23'h100));
    add("flush_end",       0, 16'h0000, 0, 2'd0, 0, 23'h0, mk(0, 0, 1, 0, 32'h0,        23'h100, 23'h100));
    add("flush_a",         0, 16'h0000, 0, 2'd0, 1, 23'h7fffff, mk(0, 0, 1, 1, 32'h0,   23'h7fffff, 23'h7fffff));
    add("flush_b",         1, 16'h1234, 0, 2'd0, 1, 23'h200, mk(0, 0, 1, 1, 32'h0,       23'h200, 23'h200));
    add("flush_b_end",     0, 16'h0000, 0, 2'd0, 0, 23'h0, mk(0, 0, 1, 0, 32'h0,        23'h200, 23'h200));
    add("flush_top",       0, 16'h0000, 0, 2'd0, 1, 23'h7fffff, mk(0, 0, 1, 1, 32'h0,   23'h7fffff, 23'h7fffff));
    add("addr_wrap",       1, 16'h0001, 0, 2'd0, 0, 23'h0, mk(1, 1, 1, 0, 32'h00000001, 23'h7fffff, 23'h0));
    add("pc_wrap",         0, 16'h0000, 1, 2'd1, 0, 23'h0, mk(0, 0, 1, 0, 32'h0,        23'h0, 23'h0));

    foreach (vecs[i]) begin
      cycle(vecs[i].mv, vecs[i].md, vecs[i].adv, vecs[i].len, vecs[i].fl, vecs[i].fa);
      check(vecs[i].name, dut_obs(), vecs[i].exp);
    end

    // Model-checked random stream starting from a known flush point
    model_reset();
    model_step(1'b0, 16'h0, 1'b0, 2'd0, 1'b1, 23'h7ffffc);
    cycle(1'b0, 16'h0, 1'b0, 2'd0, 1'b1, 23'h7ffffc);
    check("rand_start", dut_obs(), model_obs());
    random_cycles(1500);

    // Mixed C / 32-bit / C stream with push and pop every cycle
    model_step(1'b1, 16'h0001, 1'b0, 2'd0, 1'b0, 23'h0);
    cycle(1'b1, 16'h0001, 1'b0, 2'd0, 1'b0, 23'h0);
    for (int i = 0; i < 24; i++) begin
      logic [15:0] hw;
      logic [1:0]  ln;
      hw = (i % 3 == 1) ? 16'h0093 : (i % 3 == 2) ? 16'h0000 : 16'h4185;
      ln = (instr_compressed) ? 2'd1 : 2'd2;
      model_step(1'b1, hw, 1'b1, ln, 1'b0, 23'h0);
      cycle(1'b1, hw, 1'b1, ln, 1'b0, 23'h0);
      check("mixed_stream", dut_obs(), model_obs());
    end

    // Asynchronous reset mid-stream, observed between clock edges
    model_step(1'b1, 16'h0513, 1'b0, 2'd0, 1'b0, 23'h0);
    cycle(1'b1, 16'h0513, 1'b0, 2'd0, 1'b0, 23'h0);
    rst = 1'b1;
    #1;
    check("async_reset", dut_obs(), RESET_OBS);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("after_reset", dut_obs(), model_obs());
    random_cycles(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
